// File: rtl/rgmii_rx_decode_pkg.sv
// Shared definitions for the RGMII receive decoder: in-band speed encodings
// and the 10/100 nibble-assembly FSM state type.
package rgmii_rx_decode_pkg;

  // In-band / link speed encodings as carried on RXD[2:1] between frames
  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  // Nibble-assembly state: IDLE between frames, HIGH waiting for the upper
  // nibble of a byte, LOW waiting for the lower nibble of the next byte
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } rx_state_t;

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band link status tracker for the RGMII receive decoder.
// Samples RXD between frames (RX_DV=0, RX_ER=0) and only commits a new
// link/speed/duplex value after two consecutive identical samples.
// The whole module only exists when RGMII_RX_INBAND_STATUS_EN is defined;
// without it the top level ties the status outputs off instead.
`ifdef RGMII_RX_INBAND_STATUS_EN
module rgmii_inband_status
  import rgmii_rx_decode_pkg::*;
#(
  parameter logic [1:0] SPEED_DEFAULT = SPEED_1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dv,
  input  logic       er,
  input  logic [3:0] rx_d,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_full_duplex
);

  logic       sample_en;
  logic [3:0] hist_q;
  logic       hist_valid_q;

  assign sample_en = !dv && !er;

  // One-cycle history plus glitch-filtered status registers; history is
  // invalidated on any non-status cycle so only back-to-back samples match
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q           <= 4'h0;
      hist_valid_q     <= 1'b0;
      link_up          <= 1'b0;
      link_speed       <= SPEED_DEFAULT;
      link_full_duplex <= 1'b0;
    end else begin
      hist_q       <= rx_d;
      hist_valid_q <= sample_en;
      if (sample_en && hist_valid_q && (rx_d == hist_q)) begin
        link_up          <= rx_d[0];
        link_full_duplex <= rx_d[3];
        if (rx_d[2:1] != SPEED_RSVD) begin
          link_speed <= rx_d[2:1];
        end
      end
    end
  end

endmodule
`endif

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns the rising/falling IDDR samples of RXD and
// RX_CTL into a GMII-style byte stream. Gigabit mode passes one byte per
// cycle; 10/100 mode assembles nibbles into bytes qualified by gmii_clk_en.
// Optional in-band status tracking is enabled by RGMII_RX_INBAND_STATUS_EN.
module rgmii_rx_decode
  import rgmii_rx_decode_pkg::*;
#(
  parameter logic [1:0] SPEED_DEFAULT = SPEED_1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rx_d_q1,
  input  logic [3:0] rx_d_q2,
  input  logic       rx_ctl_q1,
  input  logic       rx_ctl_q2,
  input  logic       mii_select,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_clk_en,
  output logic       odd_nibble_err,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_full_duplex
);

  rx_state_t  state_q, state_d;
  logic [3:0] low_q, low_d;
  logic       low_er_q, low_er_d;
  logic [7:0] rxd_d;
  logic       dv_d, er_d, clk_en_d, odd_d;
  logic       dv, er;

  // RX_CTL carries DV on the rising edge and DV^ER on the falling edge
  assign dv = rx_ctl_q1;
  assign er = rx_ctl_q1 ^ rx_ctl_q2;

  // Next-state and next-output logic; gigabit mode parks the FSM in IDLE,
  // which also gives the forced return to IDLE on any mode change
  always_comb begin
    state_d  = state_q;
    low_d    = low_q;
    low_er_d = low_er_q;
    rxd_d    = gmii_rxd;
    dv_d     = 1'b0;
    er_d     = 1'b0;
    clk_en_d = 1'b0;
    odd_d    = 1'b0;
    if (!mii_select) begin
      rxd_d    = {rx_d_q2, rx_d_q1};
      dv_d     = dv;
      er_d     = er;
      clk_en_d = 1'b1;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dv) begin
            low_d    = rx_d_q1;
            low_er_d = er;
            state_d  = HIGH;
          end else if (er) begin
            er_d     = 1'b1;
            clk_en_d = 1'b1;
          end
        end
        HIGH: begin
          if (dv) begin
            rxd_d    = {rx_d_q1, low_q};
            dv_d     = 1'b1;
            er_d     = er | low_er_q;
            clk_en_d = 1'b1;
            state_d  = LOW;
          end else begin
            odd_d   = 1'b1;
            state_d = IDLE;
          end
        end
        LOW: begin
          if (dv) begin
            low_d    = rx_d_q1;
            low_er_d = er;
            dv_d     = 1'b1;
            state_d  = HIGH;
          end else begin
            clk_en_d = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Registered outputs and FSM state; reset drops any frame in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      low_q          <= 4'h0;
      low_er_q       <= 1'b0;
      gmii_rxd       <= 8'h00;
      gmii_rx_dv     <= 1'b0;
      gmii_rx_er     <= 1'b0;
      gmii_clk_en    <= 1'b1;
      odd_nibble_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      low_q          <= low_d;
      low_er_q       <= low_er_d;
      gmii_rxd       <= rxd_d;
      gmii_rx_dv     <= dv_d;
      gmii_rx_er     <= er_d;
      gmii_clk_en    <= clk_en_d;
      odd_nibble_err <= odd_d;
    end
  end

`ifdef RGMII_RX_INBAND_STATUS_EN
  rgmii_inband_status #(
    .SPEED_DEFAULT(SPEED_DEFAULT)
  ) u_inband_status (
    .clk              (clk),
    .rst_n            (rst_n),
    .dv               (dv),
    .er               (er),
    .rx_d             (rx_d_q1),
    .link_up          (link_up),
    .link_speed       (link_speed),
    .link_full_duplex (link_full_duplex)
  );
`else
  assign link_up          = 1'b1;
  assign link_speed       = SPEED_DEFAULT;
  assign link_full_duplex = 1'b1;
`endif

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Self-checking bench for rgmii_rx_decode: directed and randomized gigabit
// traffic, 10/100 frames of random length, false carrier, mode switching,
// mid-frame reset and in-band status (tie-offs when the feature is off).
module tb_rgmii_rx_decode;

  localparam logic [1:0] SPEED_DEF = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rx_d_q1 = 4'h0;
  logic [3:0] rx_d_q2 = 4'h0;
  logic       rx_ctl_q1 = 1'b0;
  logic       rx_ctl_q2 = 1'b0;
  logic       mii_select = 1'b0;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       gmii_clk_en;
  logic       odd_nibble_err;
  logic       link_up;
  logic [1:0] link_speed;
  logic       link_full_duplex;

  int assertions = 0;
  int failures   = 0;

  // Status reference: last status sample seen and the committed link state
  logic [3:0] st_prev;
  bit         st_prev_ok;
  logic       exp_up;
  logic [1:0] exp_speed;
  logic       exp_dup;

  // Frame description used by the 10/100 frame runner
  logic [3:0] frame_nib [64];
  bit         frame_er  [64];
  int         frame_len;
  logic [3:0] idle_nib;

  rgmii_rx_decode #(.SPEED_DEFAULT(SPEED_DEF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_d_q1          (rx_d_q1),
    .rx_d_q2          (rx_d_q2),
    .rx_ctl_q1        (rx_ctl_q1),
    .rx_ctl_q2        (rx_ctl_q2),
    .mii_select       (mii_select),
    .gmii_rxd         (gmii_rxd),
    .gmii_rx_dv       (gmii_rx_dv),
    .gmii_rx_er       (gmii_rx_er),
    .gmii_clk_en      (gmii_clk_en),
    .odd_nibble_err   (odd_nibble_err),
    .link_up          (link_up),
    .link_speed       (link_speed),
    .link_full_duplex (link_full_duplex)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Status samples are taken on cycles with neither DV nor ER; a value is
  // committed once the same sample appears on two back-to-back cycles
  task automatic updateStatusModel(input bit in_reset, input bit sampled, input logic [3:0] s);
    if (in_reset) begin
      st_prev_ok = 1'b0;
      exp_up     = 1'b0;
      exp_speed  = SPEED_DEF;
      exp_dup    = 1'b0;
    end else begin
      if (sampled && st_prev_ok && (s == st_prev)) begin
        exp_up  = s[0];
        exp_dup = s[3];
        if (s[2:1] != 2'b11) exp_speed = s[2:1];
      end
      st_prev_ok = sampled;
      st_prev    = s;
    end
  endtask

  // Drive one cycle of IDDR samples, wait past the edge, check link status
  task automatic applyStimulus(input logic [3:0] q1, input logic [3:0] q2,
                               input logic c1, input logic c2, input logic mii);
    rx_d_q1    = q1;
    rx_d_q2    = q2;
    rx_ctl_q1  = c1;
    rx_ctl_q2  = c2;
    mii_select = mii;
    @(posedge clk);
    #1;
    updateStatusModel(!rst_n, !c1 && !c2, q1);
`ifdef RGMII_RX_INBAND_STATUS_EN
    checkOutput("link_up", link_up, exp_up);
    checkOutput("link_speed", link_speed, exp_speed);
    checkOutput("link_duplex", link_full_duplex, exp_dup);
`else
    checkOutput("link_up_tie", link_up, 1'b1);
    checkOutput("link_speed_tie", link_speed, SPEED_DEF);
    checkOutput("link_duplex_tie", link_full_duplex, 1'b1);
`endif
  endtask

  // Gigabit: the byte seen one cycle later is {falling, rising} nibbles
  task automatic gigByte(input logic [7:0] b, input logic c1, input logic c2);
    applyStimulus(b[3:0], b[7:4], c1, c2, 1'b0);
    checkOutput("gig_rxd", gmii_rxd, b);
    checkOutput("gig_dv", gmii_rx_dv, c1);
    checkOutput("gig_er", gmii_rx_er, c1 ^ c2);
    checkOutput("gig_clk_en", gmii_clk_en, 1'b1);
    checkOutput("gig_odd", odd_nibble_err, 1'b0);
  endtask

  // 10/100 frame: nibble pairs (2k, 2k+1) form byte k, emitted on the cycle
  // carrying nibble 2k+1; an even-length frame closes with a dv=0 strobe,
  // an odd-length one ends with an odd_nibble_err pulse
  task automatic runMiiFrame();
    for (int i = 0; i < frame_len; i++) begin
      applyStimulus(frame_nib[i], 4'($urandom), 1'b1, !frame_er[i], 1'b1);
      if (i % 2 == 1) begin
        checkOutput("mii_clk_en_byte", gmii_clk_en, 1'b1);
        checkOutput("mii_dv_byte", gmii_rx_dv, 1'b1);
        checkOutput("mii_rxd", gmii_rxd, {frame_nib[i], frame_nib[i-1]});
        checkOutput("mii_er", gmii_rx_er, frame_er[i] | frame_er[i-1]);
      end else begin
        checkOutput("mii_clk_en_gap", gmii_clk_en, 1'b0);
      end
      checkOutput("mii_odd_inframe", odd_nibble_err, 1'b0);
    end
    applyStimulus(idle_nib, 4'($urandom), 1'b0, 1'b0, 1'b1);
    if (frame_len % 2 == 0) begin
      checkOutput("mii_close_clk_en", gmii_clk_en, 1'b1);
      checkOutput("mii_close_dv", gmii_rx_dv, 1'b0);
      checkOutput("mii_close_odd", odd_nibble_err, 1'b0);
    end else begin
      checkOutput("mii_odd_pulse", odd_nibble_err, 1'b1);
      checkOutput("mii_odd_clk_en", gmii_clk_en, 1'b0);
      checkOutput("mii_odd_dv", gmii_rx_dv, 1'b0);
    end
    applyStimulus(idle_nib, 4'($urandom), 1'b0, 1'b0, 1'b1);
    checkOutput("mii_idle_clk_en", gmii_clk_en, 1'b0);
    checkOutput("mii_idle_odd", odd_nibble_err, 1'b0);
  endtask

  // Expected values right after a reset edge
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rxd"}, gmii_rxd, 8'h00);
    checkOutput({tag, "_dv"}, gmii_rx_dv, 1'b0);
    checkOutput({tag, "_er"}, gmii_rx_er, 1'b0);
    checkOutput({tag, "_clk_en"}, gmii_clk_en, 1'b1);
    checkOutput({tag, "_odd"}, odd_nibble_err, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] n;
    bit         c1, c2;

    // Reset
    rst_n = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkResetState("reset");
    rst_n = 1'b1;

    // Gigabit preamble, SFD, then 0x01..0x40 with one error byte
    for (int i = 0; i < 7; i++) gigByte(8'h55, 1'b1, 1'b1);
    gigByte(8'hD5, 1'b1, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      b = 8'(i);
      if (i == 20) gigByte(b, 1'b1, 1'b0);
      else         gigByte(b, 1'b1, 1'b1);
    end
    gigByte(8'h00, 1'b0, 1'b0);

    // Gigabit random traffic
    for (int i = 0; i < 200; i++) gigByte(8'($urandom), 1'($urandom), 1'($urandom));

    // Switch to 10/100: first cycle is IDLE with no strobe
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("switch_clk_en", gmii_clk_en, 1'b0);
    checkOutput("switch_dv", gmii_rx_dv, 1'b0);

    // 10/100 preamble frame: 5 x15, D, 1,0,2,0
    idle_nib = 4'h0;
    for (int i = 0; i < 15; i++) begin frame_nib[i] = 4'h5; frame_er[i] = 1'b0; end
    frame_nib[15] = 4'hD; frame_nib[16] = 4'h1; frame_nib[17] = 4'h0;
    frame_nib[18] = 4'h2; frame_nib[19] = 4'h0;
    for (int i = 15; i < 20; i++) frame_er[i] = 1'b0;
    frame_len = 20;
    runMiiFrame();

    // Odd-length frame of three nibbles
    frame_nib[0] = 4'hA; frame_nib[1] = 4'h3; frame_nib[2] = 4'h7;
    for (int i = 0; i < 3; i++) frame_er[i] = 1'b0;
    frame_len = 3;
    runMiiFrame();

    // False carrier in IDLE: error strobed without dv
    applyStimulus(4'hE, 4'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("false_carrier_er", gmii_rx_er, 1'b1);
    checkOutput("false_carrier_clk_en", gmii_clk_en, 1'b1);
    checkOutput("false_carrier_dv", gmii_rx_dv, 1'b0);

    // Random 10/100 frames with occasional nibble errors
    for (int f = 0; f < 25; f++) begin
      frame_len = int'($urandom_range(1, 40));
      idle_nib  = 4'($urandom);
      for (int i = 0; i < frame_len; i++) begin
        frame_nib[i] = 4'($urandom);
        frame_er[i]  = ($urandom_range(0, 9) == 0);
      end
      runMiiFrame();
    end

    // Mode change mid-frame: FSM is forced to IDLE, no odd error afterwards
    applyStimulus(4'h9, 4'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'h6, 4'hB, 1'b0, 1'b0, 1'b0);
    checkOutput("modechg_rxd", gmii_rxd, 8'hB6);
    checkOutput("modechg_clk_en", gmii_clk_en, 1'b1);
    checkOutput("modechg_dv", gmii_rx_dv, 1'b0);
    applyStimulus(4'h6, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("modechg_back_clk_en", gmii_clk_en, 1'b0);
    checkOutput("modechg_back_odd", odd_nibble_err, 1'b0);

`ifdef RGMII_RX_INBAND_STATUS_EN
    // In-band: 1101 twice -> up, 1000M, full duplex
    applyStimulus(4'hD, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'hD, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("inband_up", link_up, 1'b1);
    checkOutput("inband_speed", link_speed, 2'b10);
    checkOutput("inband_dup", link_full_duplex, 1'b1);
    // Single-cycle glitch leaves status untouched
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'hD, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("glitch_up", link_up, 1'b1);
    // Sustained 0000: still up after one sample, down after the second
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("down_first_up", link_up, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("down_up", link_up, 1'b0);
    checkOutput("down_speed", link_speed, 2'b00);
    // Reserved speed 11 keeps the previous speed
    applyStimulus(4'h7, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h7, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("rsvd_up", link_up, 1'b1);
    checkOutput("rsvd_speed", link_speed, 2'b00);
`endif

    // Random idle status patterns, held for random durations
    for (int i = 0; i < 40; i++) begin
      n = 4'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        c1 = ($urandom_range(0, 7) == 0);
        c2 = c1;
        applyStimulus(n, 4'($urandom), c1, c2, 1'b1);
      end
    end
    frame_len = 2; frame_nib[0] = 4'h1; frame_nib[1] = 4'h2;
    frame_er[0] = 1'b0; frame_er[1] = 1'b0; idle_nib = 4'h0;
    runMiiFrame();

    // Reset while waiting for the high nibble: frame dropped silently
    applyStimulus(4'h3, 4'h0, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    applyStimulus(4'h4, 4'h0, 1'b1, 1'b1, 1'b1);
    checkResetState("midreset");
    rst_n = 1'b1;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("midreset_after_odd", odd_nibble_err, 1'b0);
    checkOutput("midreset_after_clk_en", gmii_clk_en, 1'b0);
    checkOutput("midreset_after_dv", gmii_rx_dv, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
